// File: rtl/oven_pkg.sv
// Shared definitions for the oven UI input front end: button indices,
// default 50 MHz timing constants and the per-channel repeat FSM states.
package oven_pkg;

    // Button channel indices on the btn_* buses
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_START = 2;
    localparam int BTN_TIME  = 3;

    // Defaults for the 50 MHz board clock
    localparam int N_BTN_DEFAULT           = 4;
    localparam int ACTIVE_LOW_DEFAULT      = 1;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;   // 20 ms
    localparam int REPEAT_DELAY_DEFAULT    = 25000000;  // 500 ms
    localparam int REPEAT_RATE_DEFAULT     = 5000000;   // 100 ms

    // Auto-repeat state per button
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Larger of two integers, used to size the shared repeat timer
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity normalisation, 2-FF synchroniser, debounce,
// press/release edge pulses and the auto-repeat FSM. All outputs registered.
module btn_channel
    import oven_pkg::*;
#(
    parameter int ACTIVE_LOW      = ACTIVE_LOW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int   DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] timer;
    rpt_state_t       state;

    // Normalise polarity (1 = pressed) and bring the pin into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ POL;
            sync2 <= sync1;
        end
    end

    // Accept a new state only after DEBOUNCE_CYCLES consecutive differing samples;
    // deb runs one cycle ahead of level so level and its edge pulses appear together
    always_ff @(posedge clk) begin
        if (rst) begin
            deb    <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == deb) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb    <= ~deb;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Publish the debounced level with one-cycle press/release pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= deb;
            press_pulse   <= deb & ~level;
            release_pulse <= ~deb & level;
        end
    end

    // Auto-repeat: pulse on press, again after REPEAT_DELAY, then every REPEAT_RATE;
    // deb low means level drops this cycle, so the FSM drops out without a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RPT_IDLE;
            timer        <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (!deb) begin
                state <= RPT_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (!level) begin
                            repeat_pulse <= 1'b1;
                            timer        <= TMR_W'(REPEAT_DELAY);
                            state        <= RPT_DELAY;
                        end
                    end
                    RPT_DELAY, RPT_REPEAT: begin
                        if (timer == TMR_W'(1)) begin
                            repeat_pulse <= 1'b1;
                            timer        <= TMR_W'(REPEAT_RATE);
                            state        <= RPT_REPEAT;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: begin
                        state <= RPT_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/oven_button_conditioner.sv
// Input-side front end for the oven UI: one independent btn_channel per
// pushbutton/switch, so the control FSM sees each press exactly once.
module oven_button_conditioner
    import oven_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int ACTIVE_LOW      = ACTIVE_LOW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    // One conditioner per button; channels share nothing but clock and reset
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule
